rom_scanner: RTL and testbench

ROM_SCANNER -- requirements
Module: rom_scanner

---
 rtl/rom_scanner.sv | 134 +++++++++++++
 tb/tb_rom_scanner.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_scanner.sv
// rom_scanner
//   Walks a ROM in x-major order, (0,0) .. (ROWS-1, COLS-1), and streams
//   each word out with its coordinates over a valid/ready interface.
//
// Handshake: a word moves from producer to consumer on a rising edge where
//   pix_valid and pix_ready are both 1. While pix_valid=1 and pix_ready=0,
//   pix_data/pix_x/pix_y/pix_last hold stable. pix_ready is ignored while
//   pix_valid=0. pix_valid never drops without a transfer.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   scan request (ignored while busy)
//   address_x  out  ROM row address (registered)
//   address_y  out  ROM column address (registered)
//   data       in   ROM word, combinational from address_x/address_y
//   pix_data   out  registered ROM word
//   pix_x      out  row index of pix_data
//   pix_y      out  column index of pix_data
//   pix_valid  out  pix_* holds a word
//   pix_ready  in   consumer accepts the word this cycle
//   pix_last   out  pix_data is element (ROWS-1, COLS-1)
//   busy       out  state is not IDLE
//   done       out  one-cycle pulse after the last word is accepted
module rom_scanner #(
  parameter int ROWS = 10,
  parameter int COLS = 20,
  parameter int AW   = 10,
  parameter int DW   = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic [AW-1:0] address_x,
  output logic [AW-1:0] address_y,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] pix_data,
  output logic [AW-1:0] pix_x,
  output logic [AW-1:0] pix_y,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_X = AW'(ROWS - 1);
  localparam logic [AW-1:0] LAST_Y = AW'(COLS - 1);

  state_t state;
  state_t state_next;

  logic xfer;
  logic load;
  logic at_row_end;
  logic at_end;

  assign xfer       = pix_valid & pix_ready;
  // The output register can take a new word when it is empty or is being
  // drained this same cycle.
  assign load       = (state == SCAN) && (!pix_valid || pix_ready);
  assign at_row_end = (address_y == LAST_Y);
  assign at_end     = at_row_end && (address_x == LAST_X);
  assign busy       = (state != IDLE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (load && at_end) state_next = FLUSH;
      FLUSH:   if (xfer && pix_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Address counters and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address_x <= '0;
      address_y <= '0;
      pix_data  <= '0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_valid <= 1'b0;
      pix_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        pix_data  <= data;
        pix_x     <= address_x;
        pix_y     <= address_y;
        pix_valid <= 1'b1;
        pix_last  <= at_end;
        // The final element leaves the addresses parked at the last
        // coordinate until the flush completes.
        if (!at_end) begin
          if (at_row_end) begin
            address_y <= '0;
            address_x <= address_x + AW'(1);
          end else begin
            address_y <= address_y + AW'(1);
          end
        end
      end else if (xfer) begin
        pix_valid <= 1'b0;
        pix_last  <= 1'b0;
        if (state == FLUSH) begin
          done      <= 1'b1;
          // Return to the origin so IDLE always presents (0,0).
          address_x <= '0;
          address_y <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rom_scanner.sv
// tb_rom_scanner
//   Drives two scanner instances (default 10x20 and a small 2x3) with a
//   ROM model data = 16*x + y, and checks the output stream against a
//   queue of expected words built directly from the x-major scan order.
module tb_rom_scanner;

  localparam int AW = 10;
  localparam int DW = 12;
  localparam int ROWS = 10;
  localparam int COLS = 20;
  localparam int SR = 2;
  localparam int SC = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT ----------------
  logic          start, pix_ready;
  logic [AW-1:0] address_x, address_y, pix_x, pix_y;
  logic [DW-1:0] data, pix_data;
  logic          pix_valid, pix_last, busy, done;

  assign data = DW'(16 * address_x + address_y);

  rom_scanner #(.ROWS(ROWS), .COLS(COLS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .address_x(address_x), .address_y(address_y), .data(data),
    .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .busy(busy), .done(done)
  );

  // ---------------- small DUT ----------------
  logic          s_start, s_ready;
  logic [AW-1:0] s_ax, s_ay, s_px, s_py;
  logic [DW-1:0] s_data, s_pd;
  logic          s_valid, s_last, s_busy, s_done;

  assign s_data = DW'(16 * s_ax + s_ay);

  rom_scanner #(.ROWS(SR), .COLS(SC), .AW(AW), .DW(DW)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(s_start),
    .address_x(s_ax), .address_y(s_ay), .data(s_data),
    .pix_data(s_pd), .pix_x(s_px), .pix_y(s_py),
    .pix_valid(s_valid), .pix_ready(s_ready), .pix_last(s_last),
    .busy(s_busy), .done(s_done)
  );

  // ---------------- scoreboard helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int x, input int y);
    return {AW'(x), AW'(y), DW'(16 * x + y)};
  endfunction

  // Reset in the middle of a cycle, confirm outputs clear without an edge,
  // then confirm the block sits idle with no done pulse.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_addr_x", address_x, 0);
    check("rst_addr_y", address_y, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_pix_x", pix_x, 0);
    check("rst_pix_y", pix_y, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_last", pix_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    pix_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_done", done, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_valid", pix_valid, 0);
      @(posedge clk);
      #1;
    end
  endtask

  // Full scan on the main DUT.
  //   duty       : percent chance pix_ready=1 each cycle
  //   hold0      : cycles to stall the very first word
  //   restart_at : word count at which start is pulsed again (-1 = never)
  //   abort_at   : word count at which reset is applied (-1 = never)
  task automatic run_full(input int duty, input int hold0, input int restart_at, input int abort_at);
    logic [31:0] exp_q[$];
    logic [32:0] held;
    logic [31:0] cur;
    bit stalled, restarted, seen_valid, finished;
    int words, edges, hold_cnt;

    for (int x = 0; x < ROWS; x++)
      for (int y = 0; y < COLS; y++)
        exp_q.push_back(pack(x, y));
    stalled = 0; restarted = 0; seen_valid = 0; finished = 0;
    words = 0; hold_cnt = 0; held = '0;

    pix_ready = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    edges = 1;
    #1 start = 1'b0;

    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      if (abort_at >= 0 && words == abort_at) begin
        mid_reset();
        return;
      end
      if (restart_at >= 0 && words == restart_at && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end else begin
        start = 1'b0;
      end
      if (hold_cnt < hold0) pix_ready = 1'b0;
      else pix_ready = ($urandom_range(99) < duty);

      @(negedge clk);
      cur = {pix_x, pix_y, pix_data};
      if (stalled) begin
        check("stall_valid", pix_valid, 1);
        check("stall_word", {pix_last, cur}, held);
      end
      stalled = pix_valid && !pix_ready;
      held = {pix_last, cur};
      if (pix_valid && !seen_valid) begin
        seen_valid = 1;
        check("first_valid_edge", edges, 2);
      end
      if (pix_valid && words == 0 && hold_cnt < hold0) begin
        hold_cnt++;
        check("hold_addr", {address_x, address_y}, {AW'(0), AW'(1)});
        check("hold_data", pix_data, 0);
        check("hold_busy", busy, 1);
      end
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          check("word", cur, exp_q[0]);
          check("last", pix_last, exp_q.size() == 1);
          void'(exp_q.pop_front());
          words++;
        end
      end
      if (done) begin
        finished = 1;
        check("done_words", words, ROWS * COLS);
        check("done_busy", busy, 0);
        if (duty == 100 && hold0 == 0) check("done_edge", edges, 202);
      end else begin
        check("scan_busy", busy, 1);
      end
      @(posedge clk);
      edges++;
      #1;
    end
    if (!finished) check("timeout", 0, 1);

    start = 1'b0;
    pix_ready = 1'b0;
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("idle_busy", busy, 0);
    check("idle_addr", {address_x, address_y}, 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] sq[$];
    logic [19:0] exp_addr;
    int w, k;
    bit fin;

    rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0;
    s_start = 1'b0; s_ready = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_valid", pix_valid, 0);
    check("reset_done", done, 0);
    check("reset_addr", {address_x, address_y}, 0);
    check("reset_s_valid", s_valid, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // small 2x3 scan: order, wrap and last flag
    for (int x = 0; x < SR; x++)
      for (int y = 0; y < SC; y++)
        sq.push_back(pack(x, y));
    s_ready = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b1;
    @(posedge clk);
    #1 s_start = 1'b0;
    w = 0; fin = 0;
    for (int c = 0; c < 30 && !fin; c++) begin
      @(negedge clk);
      if (s_valid) begin
        if (sq.size() == 0) begin
          check("s_extra", 1, 0);
        end else begin
          check("s_word", {s_px, s_py, s_pd}, sq[0]);
          check("s_last", s_last, sq.size() == 1);
          k = w + 1;
          exp_addr = (k < SR * SC) ? {AW'(k / SC), AW'(k % SC)} : {AW'(SR - 1), AW'(SC - 1)};
          check("s_addr", {s_ax, s_ay}, exp_addr);
          void'(sq.pop_front());
          w++;
        end
      end
      if (s_done) begin
        fin = 1;
        check("s_words", w, SR * SC);
      end
      @(posedge clk);
      #1;
    end
    if (!fin) check("s_timeout", 0, 1);
    s_ready = 1'b0;

    // main scans
    run_full(100, 0, -1, -1);   // full rate, exact timing
    run_full(30, 0, -1, -1);    // random back-pressure
    run_full(100, 10, -1, -1);  // first word held 10 cycles
    run_full(100, 0, 50, -1);   // start while busy is ignored
    run_full(100, 0, -1, 120);  // reset mid-scan
    run_full(100, 0, -1, -1);   // fresh scan after reset begins at (0,0)

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
